// File: rtl/super_pkg.sv
// Shared types for the ALU-sharing arbiter: operator encoding and the
// request/response payload records carried through the issue and response stages.
package super_pkg;

    // Widest tag the payload records can carry; the arbiter's TAG_W must not exceed it.
    localparam int TAG_MAX_W = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef struct packed {
        alu_op_e                op;
        logic [31:0]            a;
        logic [31:0]            b;
        logic [TAG_MAX_W-1:0]   tag;
    } alu_req_t;

    typedef struct packed {
        logic [31:0]            result;
        logic [TAG_MAX_W-1:0]   tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_share_arb_sel.sv
// Grant selection for the two requesters of the shared ALU.
// Default: round-robin with a 1-bit pointer.
// ALU_ARB_FIXED_PRIO_EN: requester 0 has priority, requester 1 wins once
// after STARVE_LIM consecutive contended losses.
module alu_share_arb_sel
    import super_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_valid_i,
    input  logic       xfer_i,
    output logic [1:0] grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam int CNT_W = $clog2(STARVE_LIM + 2);

    logic [CNT_W-1:0] losses;

    // Requester 0 wins contention unless requester 1 has lost STARVE_LIM times in a row
    always_comb begin
        grant_o = req_valid_i;
        if (req_valid_i == 2'b11)
            grant_o = (losses >= CNT_W'(STARVE_LIM)) ? 2'b10 : 2'b01;
    end

    // Count contended losses of requester 1; any transfer to it clears the count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            losses <= '0;
        else if (xfer_i) begin
            if (grant_o[1])
                losses <= '0;
            else if (req_valid_i[1])
                losses <= losses + 1'b1;
        end
    end
`else
    logic ptr;

    // Contention goes to the pointer side; a lone requester is always granted
    always_comb begin
        grant_o = req_valid_i;
        if (req_valid_i == 2'b11)
            grant_o = ptr ? 2'b10 : 2'b01;
    end

    // After a transfer, favour the side that did not win
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ptr <= 1'b0;
        else if (xfer_i)
            ptr <= ~grant_o[1];
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester front end for a shared combinational ALU.
// S1 (issue register) drives alu_*, S2 (response register) drives rsp_*.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority with starvation
// relief instead of round-robin (see alu_share_arb_sel).
module alu_share_arb
    import super_pkg::*;
#(
    parameter int TAG_W      = 5,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  alu_op_e [1:0]         req_op_i,
    input  logic [1:0][31:0]      req_a_i,
    input  logic [1:0][31:0]      req_b_i,
    input  logic [1:0][TAG_W-1:0] req_tag_i,
    output logic                  alu_valid_o,
    output alu_op_e               alu_operator_o,
    output logic [31:0]           alu_a_o,
    output logic [31:0]           alu_b_o,
    input  logic [31:0]           alu_result_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [TAG_W-1:0]      rsp_tag_o,
    output logic [31:0]           rsp_result_o,
    output logic [15:0]           contend_cnt_o
);

    logic [1:0]  grant;
    logic [2:1]  vld_pipe;     // [1] = S1 valid, [2] = S2 valid
    logic        s1_adv;
    logic        s1_open;
    logic        xfer;
    logic        sel_id;
    alu_req_t    req_sel;
    alu_req_t    s1_q;
    logic        s1_id;
    alu_rsp_t    s2_q;
    logic        s2_id;
    logic [15:0] contend_q;
    logic        tag_unused;

    alu_share_arb_sel #(.STARVE_LIM(STARVE_LIM)) u_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .xfer_i      (xfer),
        .grant_o     (grant)
    );

    assign s1_adv      = ~vld_pipe[2] | rsp_ready_i;
    assign s1_open     = ~vld_pipe[1] | s1_adv;
    assign req_ready_o = grant & {2{s1_open}};
    assign xfer        = |(req_valid_i & req_ready_o);
    assign sel_id      = grant[1];

    // Payload of the granted requester, tag widened to the record width
    always_comb begin
        req_sel.op  = req_op_i[sel_id];
        req_sel.a   = req_a_i[sel_id];
        req_sel.b   = req_b_i[sel_id];
        req_sel.tag = TAG_MAX_W'(req_tag_i[sel_id]);
    end

    // Stage valid bits and the contention counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe  <= '0;
            contend_q <= '0;
        end else begin
            if (s1_open)
                vld_pipe[1] <= xfer;
            if (s1_adv)
                vld_pipe[2] <= vld_pipe[1];
            if (req_valid_i == 2'b11 && contend_q != 16'hFFFF)
                contend_q <= contend_q + 16'd1;
        end
    end

    // Payload registers load only on capture so outputs hold while stalled
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            s1_q  <= req_sel;
            s1_id <= sel_id;
        end
        if (s1_adv && vld_pipe[1]) begin
            s2_q.result <= alu_result_i;
            s2_q.tag    <= s1_q.tag;
            s2_id       <= s1_id;
        end
    end

    // Tag bits above TAG_W are always zero and deliberately dropped on output
    assign tag_unused = ^s2_q.tag;

    assign alu_valid_o    = vld_pipe[1];
    assign alu_operator_o = s1_q.op;
    assign alu_a_o        = s1_q.a;
    assign alu_b_o        = s1_q.b;
    assign rsp_valid_o    = vld_pipe[2];
    assign rsp_id_o       = s2_id;
    assign rsp_tag_o      = s2_q.tag[TAG_W-1:0];
    assign rsp_result_o   = s2_q.result;
    assign contend_cnt_o  = contend_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: stimulus pushes expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_alu_share_arb;
    import super_pkg::*;

    localparam int TAG_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    alu_op_e [1:0]         req_op;
    logic [1:0][31:0]      req_a;
    logic [1:0][31:0]      req_b;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  alu_valid;
    alu_op_e               alu_operator;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [31:0]           alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_result;
    logic [15:0]           contend_cnt;

    always #5 clk = ~clk;

    alu_share_arb #(.TAG_W(TAG_W), .STARVE_LIM(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_tag_i      (req_tag),
        .alu_valid_o    (alu_valid),
        .alu_operator_o (alu_operator),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_result_i   (alu_result),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_tag_o      (rsp_tag),
        .rsp_result_o   (rsp_result),
        .contend_cnt_o  (contend_cnt)
    );

    // Shared combinational ALU seen by the arbiter
    always_comb begin
        case (alu_operator)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    // Per-requester vector tables
    alu_op_e          t_op  [2][64];
    logic [31:0]      t_a   [2][64];
    logic [31:0]      t_b   [2][64];
    logic [31:0]      t_res [2][64];
    logic [TAG_W-1:0] t_tag [2][64];
    logic [5:0]       vidx  [2];

    assign req_op[0]  = t_op[0][vidx[0]];
    assign req_op[1]  = t_op[1][vidx[1]];
    assign req_a[0]   = t_a[0][vidx[0]];
    assign req_a[1]   = t_a[1][vidx[1]];
    assign req_b[0]   = t_b[0][vidx[0]];
    assign req_b[1]   = t_b[1][vidx[1]];
    assign req_tag[0] = t_tag[0][vidx[0]];
    assign req_tag[1] = t_tag[1][vidx[1]];

    typedef struct {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL rsp_unexpected: got id=%0d tag=%0h res=%0h expected none",
                         rsp_id, rsp_tag, rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_tag !== e.tag || rsp_result !== e.res) begin
                    nerr++;
                    $display("FAIL rsp: got id=%0d tag=%0h res=%0h expected id=%0d tag=%0h res=%0h",
                             rsp_id, rsp_tag, rsp_result, e.id, e.tag, e.res);
                end
            end
        end
    end

    // One request cycle: drive valids, check expected ready, push accepted work
    task automatic issue(input logic [1:0] v, input logic [1:0] er, input string name);
        req_valid = v;
        @(negedge clk);
        check(name, {30'd0, req_ready}, {30'd0, er});
        for (int i = 0; i < 2; i++) begin
            if (er[i]) begin
                exp_t e;
                e.id  = 1'(i);
                e.tag = t_tag[i][vidx[i]];
                e.res = t_res[i][vidx[i]];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (er[i]) vidx[i] = vidx[i] + 6'd1;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0] c_exp [4];
    logic [1:0] f_exp [10];
    logic [1:0] g_exp1;
    logic [5:0] d0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) begin
                t_op[i][k]  = alu_op_e'(k % 4);
                t_a[i][k]   = 32'h0001_0000 * (i + 1) + 32'(k * 5);
                t_b[i][k]   = (i == 0) ? 32'(k * 3 + 1) : 32'h0F0F_0000 + 32'(k);
                t_tag[i][k] = TAG_W'(i * 16 + k % 16);
                case (k % 4)
                    0: t_res[i][k] = t_a[i][k] + t_b[i][k];
                    1: t_res[i][k] = t_a[i][k] - t_b[i][k];
                    2: t_res[i][k] = t_a[i][k] & t_b[i][k];
                    default: t_res[i][k] = t_a[i][k] | t_b[i][k];
                endcase
            end
        end
        // Hand vector: ADD 3 + 4, tag 5 -> 7
        t_op[0][0] = ALU_ADD; t_a[0][0] = 32'd3; t_b[0][0] = 32'd4;
        t_tag[0][0] = 5'd5;   t_res[0][0] = 32'd7;
        vidx[0] = '0; vidx[1] = '0;

`ifdef ALU_ARB_FIXED_PRIO_EN
        c_exp  = '{2'b01, 2'b01, 2'b01, 2'b01};
        f_exp  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        g_exp1 = 2'b01;
`else
        c_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};
        f_exp  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        g_exp1 = 2'b10;
`endif

        // Reset state; contention during reset must not count
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_contend", {16'd0, contend_cnt}, 32'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single request, latency N+1 / N+2
        issue(2'b01, 2'b01, "a_accept");
        req_valid = 2'b00;
        @(negedge clk);
        check("a_alu_valid", {31'd0, alu_valid}, 32'd1);
        check("a_alu_a", alu_a, 32'd3);
        check("a_alu_b", alu_b, 32'd4);
        check("a_rsp_early", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("a_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("a_rsp_result", rsp_result, 32'd7);
        @(posedge clk); #1;
        idle(2);

        // Lone requester 1 is granted regardless of pointer
        issue(2'b10, 2'b10, "b_accept");
        idle(3);

        // Contention for four cycles
        for (int k = 0; k < 4; k++) issue(2'b11, c_exp[k], "c_grant");
        idle(1);
        check("c_contend", {16'd0, contend_cnt}, 32'd4);
        idle(3);

        // Backpressure with streaming requests
        rsp_ready = 1'b0;
        d0 = vidx[0];
        issue(2'b01, 2'b01, "d_acc0");
        issue(2'b01, 2'b01, "d_acc1");
        for (int k = 0; k < 3; k++) begin
            issue(2'b01, 2'b00, "d_stall_ready");
            check("d_stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("d_stall_rsp_tag", {27'd0, rsp_tag}, {27'd0, t_tag[0][d0]});
            check("d_stall_rsp_res", rsp_result, t_res[0][d0]);
            check("d_stall_alu_a", alu_a, t_a[0][d0 + 6'd1]);
        end
        rsp_ready = 1'b1;
        issue(2'b01, 2'b01, "d_release");
        idle(4);

        // Asynchronous reset with both stages full
        rsp_ready = 1'b0;
        issue(2'b01, 2'b01, "e_fill0");
        issue(2'b01, 2'b01, "e_fill1");
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("e_alu_valid", {31'd0, alu_valid}, 32'd0);
        check("e_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("e_contend", {16'd0, contend_cnt}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        idle(5);

        // Ten contended cycles from freshly reset arbitration state
        for (int k = 0; k < 10; k++) issue(2'b11, f_exp[k], "f_grant");
        idle(4);

        // Stalled contention until the counter saturates
        rsp_ready = 1'b0;
        issue(2'b11, 2'b01, "g_acc0");
        issue(2'b11, g_exp1, "g_acc1");
        repeat (1000) @(posedge clk);
        #1;
        check("g_contend_1012", {16'd0, contend_cnt}, 32'd1012);
        check("g_stalled_ready", {30'd0, req_ready}, 32'd0);
        repeat (69000) @(posedge clk);
        #1;
        check("g_contend_sat", {16'd0, contend_cnt}, 32'h0000_FFFF);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        idle(5);
        check("g_contend_hold", {16'd0, contend_cnt}, 32'h0000_FFFF);

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
